// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU with RV32M extension:
// base ALU ops, RV32M funct3 values and the control FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes,
// with sign fix-up and the RV32M division special cases.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LAST    = SHW'(XLEN-1);

    logic              busy;
    logic [SHW-1:0]    cnt;
    logic              is_div;
    logic              upper;
    logic              neg_res;
    logic              neg_rem;
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;

    logic              sa;
    logic              sb;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod_nx;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] x,
        input logic            neg
    );
        return neg ? -x : x;
    endfunction

    // Signedness of each operand follows funct3 (div: op[0]=unsigned)
    always_comb begin
        sa = a[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
        sb = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    end

    always_comb begin
        sum     = {1'b0, prod[2*XLEN-1:XLEN]}
                + (prod[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
        prod_nx = {sum, prod[XLEN-1:1]};
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, mb};
        if (diff[XLEN]) begin
            rem_nx = shifted[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b1};
        end
    end

    // The final step is folded into the result so the capture edge
    // coincides with the last iteration.
    always_comb begin
        prod_fix = neg_res ? -prod_nx : prod_nx;
        if (div0) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end else begin
            q_fix = neg_res ? -quo_nx : quo_nx;
            r_fix = neg_rem ? -rem_nx : rem_nx;
        end
        if (is_div)
            result = upper ? r_fix : q_fix;
        else
            result = upper ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_div  <= 1'b0;
            upper   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            a_q     <= '0;
            ma      <= '0;
            mb      <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= op[2];
            upper   <= op[2] ? op[1] : (op[1:0] != 2'b00);
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            div0    <= (b == '0);
            ovf     <= op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
            a_q     <= a;
            ma      <= mag(a, sa);
            mb      <= mag(b, sb);
            prod    <= {{XLEN{1'b0}}, mag(b, sb)};
            rem     <= '0;
            quo     <= mag(a, sa);
        end else if (busy) begin
            if (is_div) begin
                rem <= rem_nx;
                quo <= quo_nx;
            end else begin
                prod <= prod_nx;
            end
            if (cnt == LAST)
                busy <= 1'b0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative RV32M,
// behind a valid/ready handshake with registered result and flags.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      operation,
    input  logic            switch,
    input  logic            muldiv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] o,
    output logic            z,
    output logic            n,
    output logic            c,
    output logic            v
);

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   addsub;
    logic [XLEN-1:0] alu_o;
    logic            alu_c;
    logic            alu_v;

    assign accept   = in_valid && in_ready;
    assign md_start = accept && muldiv;
    assign shamt    = b[SHW-1:0];

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (operation),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        addsub = switch ? ({1'b0, a} - {1'b0, b})
                        : ({1'b0, a} + {1'b0, b});
        alu_o  = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        unique case (operation)
            ALU_ADD: begin
                alu_o = addsub[XLEN-1:0];
                alu_c = addsub[XLEN];
                // overflow: operand signs (b inverted for SUB) agree, result differs
                alu_v = ((a[XLEN-1] ^ b[XLEN-1]) == switch)
                     && (addsub[XLEN-1] != a[XLEN-1]);
            end
            ALU_SLL:  alu_o = a << shamt;
            ALU_SLT:  alu_o = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_o = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  alu_o = a ^ b;
            ALU_SR:   alu_o = switch ? XLEN'($signed(a) >>> shamt)
                                     : a >> shamt;
            ALU_OR:   alu_o = a | b;
            ALU_AND:  alu_o = a & b;
            default:  alu_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)
                      state_nx = !muldiv ? DONE
                               : (operation[2] ? DIV : MUL);
            MUL,
            DIV:  if (md_done) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o <= '0;
            z <= 1'b0;
            n <= 1'b0;
            c <= 1'b0;
            v <= 1'b0;
        end else if (accept && !muldiv) begin
            o <= alu_o;
            z <= (alu_o == '0);
            n <= alu_o[XLEN-1];
            c <= alu_c;
            v <= alu_v;
        end else if (md_done && (state == MUL || state == DIV)) begin
            o <= md_result;
            z <= (md_result == '0);
            n <= md_result[XLEN-1];
            c <= 1'b0;
            v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: ALU ops, RV32M ops, latency,
// backpressure and reset abort, against hand-computed values.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  operation;
    logic        switch;
    logic        muldiv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o;
    logic        z;
    logic        n;
    logic        c;
    logic        v;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .operation (operation),
        .switch    (switch),
        .muldiv    (muldiv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic sw,
                          input logic md, input logic [31:0] aa,
                          input logic [31:0] bb);
        @(negedge clk);
        operation = op;
        switch    = sw;
        muldiv    = md;
        a         = aa;
        b         = bb;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycles counted from the accept edge; 1 = valid right after it.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
        chk("release out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic sw, input logic md,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eo, input logic [3:0] ef,
                       input int elat);
        int lat;
        launch(op, sw, md, aa, bb);
        wait_valid(lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " o"}, o, eo);
        chk({tag, " zncv"}, {28'd0, z, n, c, v}, {28'd0, ef});
        release_out();
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        operation = '0;
        switch    = 1'b0;
        muldiv    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset o", o, 32'd0);
        chk("reset zncv", {28'd0, z, n, c, v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // flags packed as {z,n,c,v}
        run("add", ALU_ADD, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010, 1);
        run("sub", ALU_ADD, 1, 0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0001, 1);
        run("sra", ALU_SR, 1, 0, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b0100, 1);
        run("srl", ALU_SR, 0, 0, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0000, 1);
        run("sltu", ALU_SLTU, 0, 0, 32'h1, 32'hFFFF_FFFF, 32'h1, 4'b0000, 1);
        run("slt", ALU_SLT, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000, 1);
        run("sll", ALU_SLL, 0, 0, 32'h1, 32'h3F, 32'h8000_0000, 4'b0100, 1);
        run("xor", ALU_XOR, 0, 0, 32'hF0F0_1234, 32'hF0F0_1234, 32'h0, 4'b1000, 1);
        run("or", ALU_OR, 0, 0, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 4'b0000, 1);
        run("and", ALU_AND, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 1);

        run("mul", MD_MUL, 0, 1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 4'b0100, 33);
        run("mulh", MD_MULH, 0, 1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 4'b0100, 33);
        run("mulhsu", MD_MULHSU, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 33);
        run("mulhu", MD_MULHU, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, 33);
        run("mul pos", MD_MUL, 1, 1, 32'd12345, 32'd100, 32'd1234500, 4'b0000, 33);

        run("div by 0", MD_DIV, 0, 1, 32'd7, 32'd0, 32'hFFFF_FFFF, 4'b0100, 33);
        run("rem by 0", MD_REM, 0, 1, 32'd7, 32'd0, 32'd7, 4'b0000, 33);
        run("div ovf", MD_DIV, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0100, 33);
        run("rem ovf", MD_REM, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 4'b1000, 33);
        run("div neg", MD_DIV, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b0100, 33);
        run("rem neg", MD_REM, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b0100, 33);
        run("divu", MD_DIVU, 0, 1, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
        run("remu", MD_REMU, 0, 1, 32'd100, 32'd7, 32'd2, 4'b0000, 33);

        // hold the result for 5 cycles while a stray request is pulsed
        launch(MD_MUL, 0, 1, 32'hFFFF_FFFE, 32'h3);
        wait_valid(lat);
        chk("bp latency", lat, 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = (i == 2);
            operation = ALU_ADD;
            muldiv    = 1'b0;
            a         = 32'd5;
            b         = 32'd5;
            @(posedge clk);
            #1;
            chk("bp o", o, 32'hFFFF_FFFA);
            chk("bp zncv", {28'd0, z, n, c, v}, 32'b0100);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp o after release", o, 32'hFFFF_FFFA);

        // reset sampled on the 10th divide iteration
        launch(MD_DIV, 0, 1, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort o", o, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run("add after abort", ALU_ADD, 0, 0, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
